// File: rtl/pcm_adc_rx.sv
// Serial-audio ADC receiver: divides clk into BCK/LRCK, deserialises DOUT (LJ or I2S)
// and presents each left/right pair on a valid/ready port with a sticky overrun flag.
module pcm_adc_rx #(
    parameter int DATA_W    = 16,
    parameter int DIV_LOG2  = 3,
    parameter int BITS_LOG2 = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dout,
    input  logic              fmt_i2s,
    input  logic              out_ready,
    input  logic              ovr_clr,
    output logic              lrck,
    output logic              bck,
    output logic [DATA_W-1:0] left,
    output logic [DATA_W-1:0] right,
    output logic              out_valid,
    output logic              overrun
);

    localparam int CW = DIV_LOG2 + BITS_LOG2 + 1;
    localparam int SW = BITS_LOG2 + 1;
    localparam logic [DIV_LOG2-1:0] STROBE_PH = DIV_LOG2'(2 ** (DIV_LOG2 - 1) - 1);
    localparam logic [SW-1:0]       WORD_SPAN = SW'(DATA_W - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              fmt_q, fmt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;

    logic [SW-1:0]     slot, first_slot, last_slot;
    logic [DATA_W:0]   word_ext;
    logic [DATA_W-1:0] word;
    logic              half, strobe, capture, word_done, pair_load, ovr_set;

    always_comb begin
        slot       = {1'b0, cnt_q[CW-2:DIV_LOG2]};
        first_slot = {{(SW-1){1'b0}}, fmt_q};
        last_slot  = first_slot + WORD_SPAN;
        half       = cnt_q[CW-1];
        strobe     = (cnt_q[DIV_LOG2-1:0] == STROBE_PH);
        capture    = strobe && (slot >= first_slot) && (slot <= last_slot);
        word_done  = capture && (slot == last_slot);
        pair_load  = word_done && half;
        word_ext   = {shift_q, dout};
        word       = word_ext[DATA_W-1:0];
        ovr_set    = pair_load && valid_q && !out_ready;
    end

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        fmt_d   = (cnt_q == '0) ? fmt_i2s : fmt_q;
        shift_d = capture ? word : shift_q;
        hold_d  = (word_done && !half) ? word : hold_q;
        left_d  = left_q;
        right_d = right_q;
        // The first half-frame carries right in LJ but left in I2S.
        if (pair_load) begin
            if (fmt_q) begin
                left_d  = hold_q;
                right_d = word;
            end else begin
                left_d  = word;
                right_d = hold_q;
            end
        end
        if (pair_load) begin
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            fmt_q   <= 1'b0;
            shift_q <= '0;
            hold_q  <= '0;
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fmt_q   <= fmt_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            left_q  <= left_d;
            right_q <= right_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bck       = cnt_q[DIV_LOG2-1];
    assign lrck      = cnt_q[CW-1];
    assign left      = left_q;
    assign right     = right_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_pcm_adc_rx.sv
// Bench for pcm_adc_rx at default parameters: an ADC model streams frame-level
// left/right words and a frame-level reference predicts clocks, pairs and flags.
module tb_pcm_adc_rx;

    localparam int FRAME = 512;
    localparam int HALF  = 256;
    localparam int BCKP  = 8;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dout = 1'b0;
    logic          fmt_i2s = 1'b0;
    logic          out_ready = 1'b1;
    logic          ovr_clr = 1'b0;
    logic          lrck, bck, out_valid, overrun;
    logic [DW-1:0] left, right;

    int checks = 0;
    int errors = 0;
    int tbCnt;

    // Reference state: what the outputs should show in the current clk cycle.
    logic [DW-1:0] mLeft = '0, mRight = '0;
    logic          mValid = 1'b0, mOvr = 1'b0;
    logic          curFmt = 1'b0;
    logic [DW-1:0] curL = '0, curR = '0;
    logic [31:0]   junk0 = '0, junk1 = '0;
    logic [31:0]   pairQ[$];

    int            cc, ss, hh, idx, loadAt, latency, mode;
    logic [DW-1:0] w;

    pcm_adc_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dout      (dout),
        .fmt_i2s   (fmt_i2s),
        .out_ready (out_ready),
        .ovr_clr   (ovr_clr),
        .lrck      (lrck),
        .bck       (bck),
        .left      (left),
        .right     (right),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] l, input logic [DW-1:0] r);
        pairQ.push_back({l, r});
    endtask

    task automatic waitCnt(input int target);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (tbCnt != target && n < 1100);
        if (tbCnt != target) checkOutput("waitCnt_timeout", 32'(tbCnt), 32'(target));
    endtask

    // Position within the LRCK frame, counted in clk cycles since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tbCnt <= 0;
        else        tbCnt <= (tbCnt + 1) % FRAME;
    end

    // Each cycle: compare outputs to the reference, start new frames, advance the
    // reference across the coming edge, and drive the ADC data bit for this cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            mLeft = '0; mRight = '0; mValid = 1'b0; mOvr = 1'b0;
        end else begin
            cc = tbCnt;
            checkOutput("bck", 32'(bck), 32'((cc % BCKP) >= BCKP / 2));
            checkOutput("lrck", 32'(lrck), 32'(cc >= HALF));
            checkOutput("out_valid", 32'(out_valid), 32'(mValid));
            checkOutput("overrun", 32'(overrun), 32'(mOvr));
            checkOutput("left", 32'(left), 32'(mLeft));
            checkOutput("right", 32'(right), 32'(mRight));

            if (cc == 0) begin
                curFmt = fmt_i2s;
                if (pairQ.size() > 0) begin
                    {curL, curR} = pairQ.pop_front();
                end else begin
                    curL = DW'($urandom);
                    curR = DW'($urandom);
                end
                junk0 = $urandom;
                junk1 = $urandom;
            end

            // Last bit of the second half-word is captured just before BCK rises in its slot.
            loadAt = HALF + (32'(curFmt) + DW - 1) * BCKP + BCKP / 2 - 1;
            if (cc == loadAt) begin
                if (mValid && !out_ready) mOvr = 1'b1;
                else if (ovr_clr)         mOvr = 1'b0;
                mLeft  = curL;
                mRight = curR;
                mValid = 1'b1;
            end else begin
                if (mValid && out_ready) mValid = 1'b0;
                if (ovr_clr)             mOvr = 1'b0;
            end

            hh  = cc / HALF;
            ss  = (cc % HALF) / BCKP;
            idx = ss - 32'(curFmt);
            w   = curFmt ? (hh != 0 ? curR : curL) : (hh != 0 ? curL : curR);
            if (idx >= 0 && idx < DW) dout = w[DW-1-idx];
            else                      dout = (hh != 0) ? junk1[ss] : junk0[ss];
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_left", 32'(left), 32'h0);
        checkOutput("rst_right", 32'(right), 32'h0);
        checkOutput("rst_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_overrun", 32'(overrun), 32'h0);
        checkOutput("rst_bck", 32'(bck), 32'h0);
        checkOutput("rst_lrck", 32'(lrck), 32'h0);

        // Frame 0 left-justified, frame 1 I2S.
        applyStimulus(16'hA5C3, 16'h1234);
        rst_n = 1'b1;
        waitCnt(10);
        applyStimulus(16'h8001, 16'h7FFE);
        fmt_i2s = 1'b1;
        waitCnt(380);
        checkOutput("lj_left", 32'(left), 32'hA5C3);
        checkOutput("lj_right", 32'(right), 32'h1234);
        checkOutput("lj_valid", 32'(out_valid), 32'h1);
        checkOutput("lj_overrun", 32'(overrun), 32'h0);
        waitCnt(381);
        checkOutput("lj_valid_drop", 32'(out_valid), 32'h0);
        waitCnt(10);
        waitCnt(388);
        checkOutput("i2s_left", 32'(left), 32'h8001);
        checkOutput("i2s_right", 32'(right), 32'h7FFE);
        checkOutput("i2s_valid", 32'(out_valid), 32'h1);

        // Two pairs arrive with nobody accepting: second overwrites first.
        applyStimulus(16'h1111, 16'h2222);
        applyStimulus(16'h3333, 16'h4444);
        fmt_i2s = 1'b0;
        waitCnt(400);
        out_ready = 1'b0;
        waitCnt(10);
        waitCnt(381);
        checkOutput("stall1_left", 32'(left), 32'h1111);
        checkOutput("stall1_overrun", 32'(overrun), 32'h0);
        waitCnt(10);
        waitCnt(381);
        checkOutput("stall2_valid", 32'(out_valid), 32'h1);
        checkOutput("stall2_left", 32'(left), 32'h3333);
        checkOutput("stall2_right", 32'(right), 32'h4444);
        checkOutput("stall2_overrun", 32'(overrun), 32'h1);
        ovr_clr = 1'b1;
        @(posedge clk);
        #2;
        ovr_clr = 1'b0;
        checkOutput("ovr_cleared", 32'(overrun), 32'h0);
        checkOutput("ovr_cleared_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("ready_drops_valid", 32'(out_valid), 32'h0);

        // Format flipped mid-frame applies only from the following frame.
        applyStimulus(16'h0F0F, 16'hF0F0);
        applyStimulus(16'h1357, 16'h2468);
        waitCnt(100);
        fmt_i2s = 1'b1;
        waitCnt(400);
        checkOutput("toggle_lj_left", 32'(left), 32'h0F0F);
        checkOutput("toggle_lj_right", 32'(right), 32'hF0F0);
        waitCnt(10);
        waitCnt(400);
        checkOutput("toggle_i2s_left", 32'(left), 32'h1357);
        checkOutput("toggle_i2s_right", 32'(right), 32'h2468);

        // Random data, consumer behaviour, clears and format changes.
        for (int f = 0; f < 12; f++) begin
            mode = $urandom_range(0, 2);
            repeat (FRAME) begin
                @(posedge clk);
                #2;
                out_ready = (mode == 2) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
                ovr_clr   = ($urandom_range(0, 63) == 0);
                if ($urandom_range(0, 299) == 0) fmt_i2s = ~fmt_i2s;
            end
        end
        out_ready = 1'b1;
        ovr_clr   = 1'b0;
        fmt_i2s   = 1'b0;

        // Reset mid-frame, then a clean restart.
        waitCnt(300);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_left", 32'(left), 32'h0);
        checkOutput("midrst_right", 32'(right), 32'h0);
        checkOutput("midrst_valid", 32'(out_valid), 32'h0);
        checkOutput("midrst_overrun", 32'(overrun), 32'h0);
        checkOutput("midrst_bck", 32'(bck), 32'h0);
        checkOutput("midrst_lrck", 32'(lrck), 32'h0);
        repeat (3) @(posedge clk);
        #2;
        applyStimulus(16'hC0DE, 16'hBEEF);
        rst_n = 1'b1;
        latency = 0;
        do begin
            @(posedge clk);
            #2;
            latency++;
        end while (!out_valid && latency < 600);
        checkOutput("restart_latency", 32'(latency), 32'd380);
        checkOutput("restart_left", 32'(left), 32'hC0DE);
        checkOutput("restart_right", 32'(right), 32'hBEEF);
        waitCnt(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcm_adc_rx.md
# pcm_adc_rx

Parametrised serial-audio ADC receiver for the PCM1801 family and other I2S or left-justified ADCs. It generates BCK and LRCK from the system clock by division and deserialises DOUT into a left/right sample pair. Each pair is presented on a valid/ready output with a one-entry holding register and a sticky overrun flag. It sits between the ADC pins and the DSP/visualisation logic, and every flop runs in the single `clk` domain.

## Interface
- `DATA_W`, default 16: sample width in bits; 1..2^BITS_LOG2-1.
- `DIV_LOG2`, default 3: BCK period = 2^DIV_LOG2 clk; must be ≥1.
- `BITS_LOG2`, default 5: BCK periods per channel = 2^BITS_LOG2; LRCK period = 2^(DIV_LOG2+BITS_LOG2+1) clk (512 at defaults).
- `clk  in  1`: system clock; also the ADC system clock (SCKI).
- `rst_n  in  1`: asynchronous, active-low reset.
- `dout  in  1`: ADC serial data, changes after BCK falls.
- `fmt_i2s  in  1`: 0 = left-justified, 1 = I2S; sampled once per frame.
- `out_ready  in  1`: consumer accepts the pair.
- `ovr_clr  in  1`: clears `overrun`.
- `lrck  out  1`: frame clock.
- `bck  out  1`: bit clock.
- `left  out  DATA_W`: left sample, MSB-first as received, two's complement untouched.
- `right  out  DATA_W`: right sample.
- `out_valid  out  1`: pair in `left`/`right` not yet accepted.
- `overrun  out  1`: sticky; an unaccepted pair was overwritten.

## Operation
- Free-running counter `cnt`, width CW = DIV_LOG2+BITS_LOG2+1, +1 per clk, wraps to 0.
- `bck` = cnt[DIV_LOG2-1]; `lrck` = cnt[CW-1]; both driven straight from flops, glitch-free.
- Slot index s = cnt[CW-2:DIV_LOG2]; half-frame H = cnt[CW-1].
- Capture strobe: cnt[DIV_LOG2-1:0] == 2^(DIV_LOG2-1)-1, the last clk before BCK rises. `dout` is shifted in at that edge.
- Format latch `fmt_q` ← `fmt_i2s` on the clk edge where cnt == 0. A change mid-frame takes effect at the next frame.
- Capture window per half-frame: slots F..F+DATA_W-1, where F = fmt_q. Slots outside the window are ignored.
- Channel map:
  - Left-justified: H=1 is left, H=0 is right.
  - I2S: H=0 is left, H=1 is right.
- H=0 word: on its final capture the full word goes to a hold register.
- H=1 word: on its final capture the completed pair (hold + new word, mapped per format) loads `left`/`right` and `out_valid` ← 1.
- Handshake:
  - Transfer happens in any cycle with out_valid && out_ready.
  - After a transfer, `out_valid` ← 0 unless a new pair loads in that same cycle; then it stays 1 with new data and no overrun.
- Overwrite: a new pair loads while out_valid && !out_ready. Data is replaced, `out_valid` stays 1, `overrun` ← 1.
- `overrun`:
  - Cleared by `ovr_clr`.
  - Set wins over clear in the same cycle.
  - Otherwise holds.
- The first frame after reset is captured normally. No warm-up discard is performed.

## Timing
- Reset values: cnt=0, lrck=0, bck=0, left=0, right=0, out_valid=0, overrun=0, fmt_q=0, shift/hold regs = 0.
- Reset is asynchronous assert; all logic runs from the first rising clk after rst_n=1.
- Output latency: the pair is visible the cycle after the capture edge of the last H=1 bit.
  - At defaults, LJ: the edge at cnt=379 (256+15·8+3); I2S: the edge at cnt=387.
- Pair rate: exactly one per LRCK period.
- Minimum consumer response: out_ready may stay low up to 511 clk (defaults) without overrun.
- Reset mid-frame: partial words are discarded, and counter and clocks restart at 0.

## Test plan
- LJ, defaults, ADC model sends left=0xA5C3, right=0x1234, out_ready=1 → left=0xA5C3, right=0x1234; out_valid high one cycle following the cnt=379 edge; overrun=0.
- I2S, fmt_i2s=1 set before frame 0, left=0x8001, right=0x7FFE → left=0x8001, right=0x7FFE; out_valid after the cnt=387 edge; bits at slot 0 and slot 17 are ignored.
- Check `bck`/`lrck` over 2 frames → bck period 8 clk 50% duty; lrck period 512 clk; lrck toggles at bck falling.
- out_ready=0 for 2 frames (pairs 0x1111/0x2222 then 0x3333/0x4444) → out_valid stays 1, data = 0x3333/0x4444, overrun=1. A single-cycle ovr_clr then clears it, and out_ready=1 drops out_valid.
- Toggle fmt_i2s at cnt=100 → the current frame still decodes as LJ; the next frame decodes as I2S.
- rst_n low at cnt=300 for 3 clk → all outputs 0 immediately; after release the first pair appears 380 clk later with correct data.
